// File: rtl/gf_mac_serial.sv
// GF(2^N) add / bit-serial multiply / multiply-accumulate unit with valid/ready
// handshakes. One product every N cycles, MSB-first shift-and-reduce.
module gf_mac_serial #(
  parameter int unsigned     N    = 8,
  parameter logic [N-1:0]    POLY = 8'h1B
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out,
  output logic [N-1:0] acc
);

  localparam int unsigned CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_MUL = 2'b01,
                            OP_MAC = 2'b10, OP_CLR = 2'b11} op_e;

  state_e        state_q;
  op_e           op_q;
  logic [N-1:0]  a_q, b_q, p_q, p_d, out_q, acc_q;
  logic [CW-1:0] cnt_q;

  // One Horner step: multiply running product by x, reduce, add a if bit set.
  always_comb begin
    p_d = {p_q[N-2:0], 1'b0};
    if (p_q[N-1])    p_d = p_d ^ POLY;
    if (b_q[cnt_q])  p_d = p_d ^ a_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      acc_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op_e'(op);
            p_q   <= '0;
            cnt_q <= CW'(N - 1);
            case (op_e'(op))
              OP_ADD: begin
                out_q   <= a ^ b;
                state_q <= DONE;
              end
              OP_CLR: begin
                out_q   <= '0;
                acc_q   <= '0;
                state_q <= DONE;
              end
              default: state_q <= BUSY;
            endcase
          end
        end
        BUSY: begin
          p_q <= p_d;
          if (cnt_q == '0) begin
            state_q <= DONE;
            if (op_q == OP_MAC) begin
              out_q <= p_d ^ acc_q;
              acc_q <= p_d ^ acc_q;
            end else begin
              out_q <= p_d;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = out_q;
  assign acc       = acc_q;

endmodule
